// File: rtl/cv32e40x_mult_sliced.sv
`timescale 1ns/1ps
// cv32e40x_mult_sliced
//   EX-stage integer multiplier. MUL (low word) is produced combinationally
//   in IDLE. MULH/MULHSU/MULHU capture 33-bit sign-extended operands on accept
//   and accumulate SLICE_W x SLICE_W partial products, one per cycle, into a
//   66-bit signed accumulator; the high word is presented from DONE.
//
// Parameters
//   SLICE_W  partial-product slice width (8, 16 or 32); N = 32/SLICE_W
//
// Configuration macro
//   CV32E40X_MULT_EARLY_TERM_EN  when defined, finish early once the remaining
//                                B slices (and B's extension bit) are all zero
//
// Ports
//   clk, rst_n      clock, synchronous active-low reset
//   valid_i         operation request
//   operator_i      0 = MUL_M32 (low word), 1 = MUL_H (high word)
//   short_signed_i  [0] op_a signed, [1] op_b signed
//   op_a_i, op_b_i  operands
//   kill_i          flush; abandons any in-flight MUL_H
//   result_o        result, valid while valid_o = 1
//   ready_o         request accepted when valid_i && ready_o
//   valid_o         result_o valid
//   ready_i         downstream accepts the result
module cv32e40x_mult_sliced #(
  parameter int SLICE_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic        operator_i,
  input  logic [1:0]  short_signed_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic        kill_i,
  output logic [31:0] result_o,
  output logic        ready_o,
  output logic        valid_o,
  input  logic        ready_i
);

  localparam int N     = 32 / SLICE_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int PP_W  = 2 * SLICE_W + 2;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  typedef enum logic {MUL_M32 = 1'b0, MUL_H = 1'b1} mul_opcode_e;

  state_e             state_q;
  mul_opcode_e        op;
  logic signed [65:0] acc_q;
  logic [32:0]        op_a_q;
  logic [32:0]        op_b_q;
  logic [IDX_W-1:0]   i_q;
  logic [IDX_W-1:0]   j_q;

  logic signed [SLICE_W:0] a_slc;
  logic signed [SLICE_W:0] b_slc;
  logic signed [PP_W-1:0]  pp;
  logic signed [65:0]      pp_sh;
  logic [6:0]              shamt;
  logic                    last_step;
  logic                    h_accept;
  logic                    b_rest_zero;
  logic [31:0]             mul_lo;

  assign op = mul_opcode_e'(operator_i);

  // Low slices are zero-extended; only the top slice carries the operand's
  // extension bit, which makes each slice a correct signed digit.
  always_comb begin
    a_slc = {1'b0, op_a_q[i_q*SLICE_W +: SLICE_W]};
    b_slc = {1'b0, op_b_q[j_q*SLICE_W +: SLICE_W]};
    if (i_q == IDX_W'(N-1)) a_slc[SLICE_W] = op_a_q[32];
    if (j_q == IDX_W'(N-1)) b_slc[SLICE_W] = op_b_q[32];
  end

  assign pp        = a_slc * b_slc;
  assign shamt     = 7'(SLICE_W) * (7'(i_q) + 7'(j_q));
  assign pp_sh     = 66'(pp) <<< shamt;
  assign last_step = (i_q == IDX_W'(N-1)) && (j_q == IDX_W'(N-1));
  assign h_accept  = (state_q == IDLE) && valid_i && !kill_i && (op == MUL_H);
  assign mul_lo    = op_a_i * op_b_i;

`ifdef CV32E40X_MULT_EARLY_TERM_EN
  // Checked only at the start of each B row: if every B bit from this slice
  // up (including the extension bit) is zero, no further product contributes.
  assign b_rest_zero = (i_q == '0) && ((op_b_q >> (j_q * SLICE_W)) == '0);
`else
  assign b_rest_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (h_accept) begin
            op_a_q  <= {short_signed_i[0] & op_a_i[31], op_a_i};
            op_b_q  <= {short_signed_i[1] & op_b_i[31], op_b_i};
            acc_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            state_q <= CALC;
          end
        end
        CALC: begin
          if (kill_i) begin
            acc_q   <= '0;
            state_q <= IDLE;
          end else if (b_rest_zero) begin
            state_q <= DONE;
          end else begin
            acc_q <= acc_q + pp_sh;
            if (last_step) begin
              state_q <= DONE;
            end else begin
              // i wraps naturally at N since N is a power of two
              i_q <= i_q + 1'b1;
              if (i_q == IDX_W'(N-1)) j_q <= j_q + 1'b1;
            end
          end
        end
        DONE: begin
          if (kill_i) begin
            acc_q   <= '0;
            state_q <= IDLE;
          end else if (ready_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    valid_o  = 1'b0;
    ready_o  = 1'b0;
    result_o = acc_q[63:32];
    case (state_q)
      IDLE: begin
        result_o = mul_lo;
        if (op == MUL_M32) begin
          valid_o = valid_i && !kill_i;
          ready_o = ready_i && !kill_i;
        end else begin
          ready_o = !kill_i;
        end
      end
      DONE:    valid_o = !kill_i;
      default: ;
    endcase
  end

endmodule
